// File: rtl/ramio_arbiter.sv
// ramio_arbiter: shares one ramio client port between the data port (m0) and the fetch port (m1).
// Define RAMIO_ARBITER_ROUND_ROBIN_EN to replace fixed m0 priority with alternating tie-breaks.
module ramio_arbiter #(
    parameter int AddressBitWidth = 32,
    parameter int DataBitWidth    = 32,
    parameter int TimeoutCycles   = 4096
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       m0_req,
    input  logic [2:0]                 m0_read_type,
    input  logic [1:0]                 m0_write_type,
    input  logic [AddressBitWidth-1:0] m0_address,
    input  logic [DataBitWidth-1:0]    m0_data_in,
    output logic [DataBitWidth-1:0]    m0_data_out,
    output logic                       m0_done,
    output logic                       m0_error,

    input  logic                       m1_req,
    input  logic [2:0]                 m1_read_type,
    input  logic [1:0]                 m1_write_type,
    input  logic [AddressBitWidth-1:0] m1_address,
    input  logic [DataBitWidth-1:0]    m1_data_in,
    output logic [DataBitWidth-1:0]    m1_data_out,
    output logic                       m1_done,
    output logic                       m1_error,

    output logic                       ram_enable,
    output logic [2:0]                 ram_read_type,
    output logic [1:0]                 ram_write_type,
    output logic [AddressBitWidth-1:0] ram_address,
    output logic [DataBitWidth-1:0]    ram_data_in,
    input  logic [DataBitWidth-1:0]    ram_data_out,
    input  logic                       ram_data_out_ready,
    input  logic                       ram_busy,

    output logic                       grant,
    output logic                       active
);

    localparam int CountWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CountWidth-1:0] CountLast =
        (TimeoutCycles > 0) ? CountWidth'(TimeoutCycles - 1) : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                       state_reg;
    logic                         grant_reg;
    logic [2:0]                   read_type_reg;
    logic [1:0]                   write_type_reg;
    logic [AddressBitWidth-1:0]   address_reg;
    logic [DataBitWidth-1:0]      wdata_reg;
    logic [CountWidth-1:0]        count_reg;
    logic [1:0]                   done_reg;
    logic [1:0]                   error_reg;
    logic [DataBitWidth-1:0]      data_out_reg [2];

    logic                         pick_m1;
    logic [2:0]                   sel_read_type;
    logic [1:0]                   sel_write_type;
    logic [AddressBitWidth-1:0]   sel_address;
    logic [DataBitWidth-1:0]      sel_data;
    logic                         complete;
    logic                         timeout_hit;

`ifdef RAMIO_ARBITER_ROUND_ROBIN_EN
    // Starts at 1 so that m0 takes the very first tie.
    logic last_owner_reg;
    assign pick_m1 = m1_req && (!m0_req || !last_owner_reg);
`else
    assign pick_m1 = m1_req && !m0_req;
`endif

    assign sel_read_type  = pick_m1 ? m1_read_type  : m0_read_type;
    assign sel_write_type = pick_m1 ? m1_write_type : m0_write_type;
    assign sel_address    = pick_m1 ? m1_address    : m0_address;
    assign sel_data       = pick_m1 ? m1_data_in    : m0_data_in;

    // Writes finish as soon as ramio is idle; reads also need the data strobe.
    assign complete    = !ram_busy && ((write_type_reg != 2'd0) || ram_data_out_ready);
    assign timeout_hit = (TimeoutCycles != 0) && (count_reg == CountLast);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            grant_reg       <= 1'b0;
            read_type_reg   <= '0;
            write_type_reg  <= '0;
            address_reg     <= '0;
            wdata_reg       <= '0;
            count_reg       <= '0;
            done_reg        <= '0;
            error_reg       <= '0;
            data_out_reg[0] <= '0;
            data_out_reg[1] <= '0;
`ifdef RAMIO_ARBITER_ROUND_ROBIN_EN
            last_owner_reg  <= 1'b1;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        grant_reg      <= pick_m1;
`ifdef RAMIO_ARBITER_ROUND_ROBIN_EN
                        last_owner_reg <= pick_m1;
`endif
                        write_type_reg <= sel_write_type;
                        read_type_reg  <= (sel_write_type != 2'd0) ? 3'd0 : sel_read_type;
                        address_reg    <= sel_address;
                        wdata_reg      <= sel_data;
                        count_reg      <= '0;
                        if (sel_write_type == 2'd0 && sel_read_type == 3'd0) begin
                            // Null request: answer without touching ramio.
                            data_out_reg[pick_m1] <= '0;
                            done_reg[pick_m1]     <= 1'b1;
                            state_reg             <= DONE;
                        end else begin
                            state_reg <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (complete) begin
                        if (write_type_reg == 2'd0) begin
                            data_out_reg[grant_reg] <= ram_data_out;
                        end
                        done_reg[grant_reg] <= 1'b1;
                        state_reg           <= DONE;
                    end else if (timeout_hit) begin
                        data_out_reg[grant_reg] <= '1;
                        error_reg[grant_reg]    <= 1'b1;
                        done_reg[grant_reg]     <= 1'b1;
                        state_reg               <= DONE;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
                DONE: begin
                    done_reg  <= '0;
                    error_reg <= '0;
                    count_reg <= '0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // ramio sees the latched request only while ACCESS is active.
    assign ram_enable     = (state_reg == ACCESS);
    assign ram_read_type  = ram_enable ? read_type_reg  : '0;
    assign ram_write_type = ram_enable ? write_type_reg : '0;
    assign ram_address    = ram_enable ? address_reg    : '0;
    assign ram_data_in    = ram_enable ? wdata_reg      : '0;
    assign active         = ram_enable;
    assign grant          = grant_reg;

    assign m0_done     = done_reg[0];
    assign m1_done     = done_reg[1];
    assign m0_error    = error_reg[0];
    assign m1_error    = error_reg[1];
    assign m0_data_out = data_out_reg[0];
    assign m1_data_out = data_out_reg[1];

endmodule

// File: tb/tb_ramio_arbiter.sv
// tb_ramio_arbiter: randomized transactions against a per-transaction latency/result model.
// Honours RAMIO_ARBITER_ROUND_ROBIN_EN for the expected tie winner.
module tb_ramio_arbiter;

    localparam int T = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_v  [2];
    logic [2:0]  rt_v   [2];
    logic [1:0]  wt_v   [2];
    logic [31:0] addr_v [2];
    logic [31:0] din_v  [2];

    logic [31:0] m0_data_out, m1_data_out;
    logic        m0_done, m1_done, m0_error, m1_error;
    logic        ram_enable;
    logic [2:0]  ram_read_type;
    logic [1:0]  ram_write_type;
    logic [31:0] ram_address, ram_data_in;
    logic [31:0] ram_data_out = '0;
    logic        ram_data_out_ready = 1'b0;
    logic        ram_busy = 1'b0;
    logic        grant, active;

    int checks = 0;
    int passes = 0;

    logic [31:0] exp_data [2];
    logic        last_owner;

    ramio_arbiter #(.AddressBitWidth(32), .DataBitWidth(32), .TimeoutCycles(T)) dut (
        .clk(clk), .rst(rst),
        .m0_req(req_v[0]), .m0_read_type(rt_v[0]), .m0_write_type(wt_v[0]),
        .m0_address(addr_v[0]), .m0_data_in(din_v[0]), .m0_data_out(m0_data_out),
        .m0_done(m0_done), .m0_error(m0_error),
        .m1_req(req_v[1]), .m1_read_type(rt_v[1]), .m1_write_type(wt_v[1]),
        .m1_address(addr_v[1]), .m1_data_in(din_v[1]), .m1_data_out(m1_data_out),
        .m1_done(m1_done), .m1_error(m1_error),
        .ram_enable(ram_enable), .ram_read_type(ram_read_type), .ram_write_type(ram_write_type),
        .ram_address(ram_address), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
        .ram_data_out_ready(ram_data_out_ready), .ram_busy(ram_busy),
        .grant(grant), .active(active)
    );

    function automatic logic done_of(input int p);
        return (p == 1) ? m1_done : m0_done;
    endfunction
    function automatic logic err_of(input int p);
        return (p == 1) ? m1_error : m0_error;
    endfunction
    function automatic logic [31:0] dout_of(input int p);
        return (p == 1) ? m1_data_out : m0_data_out;
    endfunction

    task automatic set_port(input int p, input logic [2:0] rt, input logic [1:0] wt,
                            input logic [31:0] addr, input logic [31:0] din);
        req_v[p] = 1'b1; rt_v[p] = rt; wt_v[p] = wt; addr_v[p] = addr; din_v[p] = din;
    endtask

    task automatic model_reset();
        exp_data[0] = '0;
        exp_data[1] = '0;
        last_owner  = 1'b1;
    endtask

    // Serves one transaction from the current requests. ramio is busy for the first bb
    // ACCESS cycles and strobes ready from ACCESS cycle rr on.
    task automatic do_txn(input string name, input int bb, input int rr,
                          input logic [31:0] rdata, input bit wiggle, output int w);
        int          lose, done_k, e_exp, en_cnt, c;
        bit          seen, tout;
        logic [2:0]  ert;
        logic [1:0]  ewt;
        logic [31:0] eaddr, edin, exp_out;
        if (req_v[0] && req_v[1]) begin
`ifdef RAMIO_ARBITER_ROUND_ROBIN_EN
            w = last_owner ? 0 : 1;
`else
            w = 0;
`endif
        end else begin
            w = req_v[1] ? 1 : 0;
        end
        lose = 1 - w;
        last_owner = w[0];
        ewt   = wt_v[w];
        ert   = (ewt != 2'd0) ? 3'd0 : rt_v[w];
        eaddr = addr_v[w];
        edin  = din_v[w];
        tout  = 1'b0;
        if (ewt == 2'd0 && ert == 3'd0) begin
            e_exp = 0; exp_out = '0;
        end else begin
            done_k = (ewt != 2'd0) ? bb : ((bb > rr) ? bb : rr);
            if (done_k < T) begin
                e_exp = done_k + 1;
                exp_out = (ewt != 2'd0) ? exp_data[w] : rdata;
            end else begin
                e_exp = T; tout = 1'b1; exp_out = '1;
            end
        end
        en_cnt = 0;
        seen = 1'b0;
        for (c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            checks++;
            if (ram_enable) begin
                if ({ram_address, ram_data_in, ram_read_type, ram_write_type, grant, active} !==
                    {eaddr, edin, ert, ewt, w[0], 1'b1}) begin
                    $display("FAIL %s ram_bus: got addr=%h din=%h rt=%0d wt=%0d grant=%0b active=%0b, want addr=%h din=%h rt=%0d wt=%0d grant=%0d",
                             name, ram_address, ram_data_in, ram_read_type, ram_write_type, grant, active,
                             eaddr, edin, ert, ewt, w);
                end else passes++;
                ram_busy = (en_cnt < bb);
                ram_data_out_ready = (en_cnt >= rr);
                ram_data_out = rdata;
                en_cnt++;
                if (wiggle) begin
                    addr_v[w] = $urandom; din_v[w] = $urandom;
                    rt_v[w] = 3'($urandom); wt_v[w] = 2'($urandom);
                end
            end else begin
                if ({ram_address, ram_data_in, ram_read_type, ram_write_type, active} !== '0) begin
                    $display("FAIL %s ram_idle: got addr=%h din=%h rt=%0d wt=%0d active=%0b, want all 0",
                             name, ram_address, ram_data_in, ram_read_type, ram_write_type, active);
                end else passes++;
                ram_busy = 1'($urandom);
                ram_data_out_ready = 1'($urandom);
                ram_data_out = $urandom;
            end
            checks++;
            if (done_of(lose) !== 1'b0) begin
                $display("FAIL %s loser_done: got m%0d_done=%b want 0", name, lose, done_of(lose));
            end else passes++;
            if (done_of(w) === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (c != e_exp + 1 || en_cnt != e_exp) begin
                    $display("FAIL %s latency: got done_cycle=%0d enable_cycles=%0d want %0d/%0d",
                             name, c, en_cnt, e_exp + 1, e_exp);
                end else passes++;
                checks++;
                if ({err_of(w), dout_of(w), grant} !== {tout, exp_out, w[0]}) begin
                    $display("FAIL %s result: got m%0d err=%b data=%h grant=%b want err=%b data=%h grant=%0d",
                             name, w, err_of(w), dout_of(w), grant, tout, exp_out, w);
                end else passes++;
                checks++;
                if (dout_of(lose) !== exp_data[lose] || err_of(lose) !== 1'b0) begin
                    $display("FAIL %s loser_data: got m%0d data=%h err=%b want data=%h err=0",
                             name, lose, dout_of(lose), err_of(lose), exp_data[lose]);
                end else passes++;
                exp_data[w] = exp_out;
                req_v[w] = 1'b0;
            end
        end
        if (!seen) begin
            checks++;
            $display("FAIL %s no_done: m%0d_done never seen within 40 cycles", name, w);
        end
        // One IDLE cycle always separates transactions.
        @(negedge clk);
        checks++;
        if ({active, ram_enable, m0_done, m1_done, m0_error, m1_error} !== 6'b0) begin
            $display("FAIL %s idle_gap: got active=%b en=%b done=%b%b err=%b%b want all 0",
                     name, active, ram_enable, m1_done, m0_done, m1_error, m0_error);
        end else passes++;
        $display("txn %s: m%0d rt=%0d wt=%0d addr=%h bb=%0d rr=%0d -> data=%h err=%0b",
                 name, w, ert, ewt, eaddr, bb, rr, exp_out, tout);
    endtask

    task automatic test_reset();
        for (int p = 0; p < 2; p++) begin
            req_v[p] = 1'b0; rt_v[p] = '0; wt_v[p] = '0; addr_v[p] = '0; din_v[p] = '0;
        end
        model_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({ram_enable, ram_read_type, ram_write_type, ram_address, ram_data_in, m0_done, m1_done,
             m0_error, m1_error, m0_data_out, m1_data_out, grant, active} !== '0) begin
            $display("FAIL reset_state: got en=%b addr=%h din=%h d0=%h d1=%h done=%b%b grant=%b want all 0",
                     ram_enable, ram_address, ram_data_in, m0_data_out, m1_data_out, m1_done, m0_done, grant);
        end else passes++;
        rst = 1'b0;
        $display("reset released");
    endtask

    task automatic test_read_word();
        int w;
        set_port(1, 3'd2, 2'd0, 32'h0000_0010, 32'h0);
        do_txn("m1_read_word", 0, 0, 32'hDEAD_BEEF, 1'b0, w);
    endtask

    task automatic test_byte_write();
        int w;
        set_port(0, 3'd0, 2'b01, 32'h0000_0003, 32'h0000_005A);
        do_txn("m0_byte_write", 5, 0, 32'h1234_5678, 1'b0, w);
    endtask

    task automatic test_null_and_both_types();
        int w;
        set_port(0, 3'd0, 2'd0, 32'h0000_0100, 32'h1);
        do_txn("m0_null", 0, 0, 32'hAAAA_AAAA, 1'b0, w);
        set_port(1, 3'd5, 2'd2, 32'h0000_0200, 32'hCAFE_F00D);
        do_txn("m1_read_and_write", 2, 0, 32'h5555_5555, 1'b0, w);
    endtask

    task automatic test_timeout();
        int w;
        set_port(0, 3'd2, 2'd0, 32'h0000_0040, 32'h0);
        do_txn("m0_read_timeout", 100, 0, 32'h0BAD_0BAD, 1'b0, w);
        set_port(1, 3'd0, 2'd3, 32'h0000_0044, 32'h7777_7777);
        do_txn("m1_write_timeout", 100, 0, 32'h0, 1'b0, w);
        set_port(0, 3'd1, 2'd0, 32'h0000_0048, 32'h0);
        do_txn("m0_read_last_cycle", T - 1, T - 1, 32'h1357_9BDF, 1'b0, w);
    endtask

    task automatic test_tie();
        int w, prev;
        set_port(0, 3'd2, 2'd0, 32'h0000_1000, 32'h0);
        set_port(1, 3'd2, 2'd0, 32'h0000_2000, 32'h0);
        do_txn("tie_first", 1, 1, 32'h1111_0000, 1'b0, w);
        prev = w;
        do_txn("tie_second", 0, 0, 32'h2222_0000, 1'b0, w);
        checks++;
        if (w == prev) begin
            $display("FAIL tie_order: got grants %0d then %0d want both requesters served", prev, w);
        end else passes++;
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            for (int p = 0; p < 2; p++)
                if (!req_v[p]) set_port(p, 3'd2, 2'd0, 32'h0000_3000 + 32'(p * 4), 32'h0);
            do_txn("tie_repeat", 0, 0, $urandom, 1'b0, w);
            checks++;
`ifdef RAMIO_ARBITER_ROUND_ROBIN_EN
            if (w == prev) begin
                $display("FAIL tie_alternate: got grant %0d twice in a row want alternation", w);
            end else passes++;
`else
            if (w != 0) begin
                $display("FAIL tie_priority: got grant %0d want 0", w);
            end else passes++;
`endif
            prev = w;
        end
        while (req_v[0] || req_v[1]) do_txn("tie_drain", 0, 0, $urandom, 1'b0, w);
    endtask

    task automatic test_reset_mid_access();
        int w;
        set_port(0, 3'd2, 2'd0, 32'h0000_0080, 32'h0);
        ram_busy = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (ram_enable !== 1'b1) begin
            $display("FAIL rst_mid_pre: got ram_enable=%b want 1", ram_enable);
        end else passes++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ram_enable, active} !== 2'b00) begin
            $display("FAIL rst_mid_async: got en=%b active=%b want 0 0", ram_enable, active);
        end else passes++;
        @(negedge clk);
        checks++;
        if ({m0_done, m1_done, m0_data_out, m1_data_out} !== '0) begin
            $display("FAIL rst_mid_done: got done=%b%b d0=%h d1=%h want 0", m1_done, m0_done, m0_data_out, m1_data_out);
        end else passes++;
        model_reset();
        rst = 1'b0;
        do_txn("rst_rearb", 2, 1, 32'h600D_600D, 1'b0, w);
    endtask

    task automatic test_random();
        int w, kind, bb;
        logic [2:0] rt;
        logic [1:0] wt;
        for (int i = 0; i < 30; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!req_v[p] && $urandom_range(0, 2) != 0) begin
                    kind = $urandom_range(0, 9);
                    if (kind == 0) begin rt = 3'd0; wt = 2'd0; end
                    else if (kind < 5) begin rt = 3'($urandom_range(1, 7)); wt = 2'd0; end
                    else if (kind < 9) begin rt = 3'd0; wt = 2'($urandom_range(1, 3)); end
                    else begin rt = 3'($urandom_range(1, 7)); wt = 2'($urandom_range(1, 3)); end
                    set_port(p, rt, wt, $urandom, $urandom);
                end
            end
            if (!req_v[0] && !req_v[1]) set_port($urandom_range(0, 1), 3'd2, 2'd0, $urandom, $urandom);
            bb = ($urandom_range(0, 7) == 0) ? 12 : $urandom_range(0, 4);
            do_txn("random", bb, $urandom_range(0, 4), $urandom, 1'b1, w);
        end
    endtask

    initial begin
        test_reset();
        test_read_word();
        test_byte_write();
        test_null_and_both_types();
        test_timeout();
        test_tie();
        test_reset_mid_access();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
